// File: rtl/ray_frame_buffer_db.sv
// Double-buffered RGB565 frame buffer between the ray pipeline (writes) and HDMI video (reads).
// The back bank fills over valid/ready; banks swap only at end of video frame once it is complete.
module ray_frame_buffer_db #(
  parameter int FB_WIDTH  = 320,
  parameter int FB_HEIGHT = 240,
  parameter int PIXEL_W   = 16,
  parameter int SCALE_X   = 4,
  parameter int SCALE_Y   = 3,
  parameter int ADDR_W    = 17
) (
  input  logic               pixel_clk_in,
  input  logic               rst_in,
  input  logic [10:0]        hcount_in,
  input  logic [9:0]         vcount_in,
  input  logic               video_last_pixel_in,
  input  logic               wr_valid_in,
  output logic               wr_ready_out,
  input  logic [ADDR_W-1:0]  wr_addr_in,
  input  logic [PIXEL_W-1:0] wr_pixel_in,
  input  logic               wr_last_in,
  output logic [23:0]        rgb_out,
  output logic               front_bank_out,
  output logic               swap_pending_out,
  output logic               repeat_frame_out
);
  // state     | meaning
  // ST_FILL   | accepting beats into the back bank
  // ST_WAIT   | back frame complete, writes held off until end of video frame
  typedef enum logic {ST_FILL, ST_WAIT} state_t;

  localparam int NPIX     = FB_WIDTH * FB_HEIGHT;
  localparam int H_ACTIVE = FB_WIDTH * SCALE_X;
  localparam int V_ACTIVE = FB_HEIGHT * SCALE_Y;

  state_t r_state, w_state_nxt;
  logic   r_front, w_front_nxt;
  logic   r_repeat, w_repeat;
  logic   w_fire, w_wr_en;

  logic [PIXEL_W-1:0] r_mem0 [NPIX];
  logic [PIXEL_W-1:0] r_mem1 [NPIX];

  logic [ADDR_W-1:0]  r_raddr_d1, w_raddr;
  logic               r_act_d1, r_bank_d1, r_act_d2, w_act;
  logic [PIXEL_W-1:0] r_data_d2;

  assign wr_ready_out     = (r_state == ST_FILL);
  assign swap_pending_out = (r_state == ST_WAIT);
  assign front_bank_out   = r_front;
  assign repeat_frame_out = r_repeat;
  assign w_fire           = wr_valid_in && wr_ready_out;
  assign w_wr_en          = w_fire && (int'(wr_addr_in) < NPIX);

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state  <= ST_FILL;
      r_front  <= 1'b0;
      r_repeat <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_front  <= w_front_nxt;
      r_repeat <= w_repeat;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_front_nxt = r_front;
    w_repeat    = 1'b0;
    case (r_state)
      ST_FILL: begin
        // a last beat coinciding with end of frame swaps at once and keeps filling
        if (w_fire && wr_last_in) begin
          if (video_last_pixel_in) w_front_nxt = ~r_front;
          else                     w_state_nxt = ST_WAIT;
        end else if (video_last_pixel_in) begin
          w_repeat = 1'b1;
        end
      end
      ST_WAIT: begin
        if (video_last_pixel_in) begin
          w_front_nxt = ~r_front;
          w_state_nxt = ST_FILL;
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge pixel_clk_in) begin
    if (w_wr_en && r_front) r_mem0[wr_addr_in] <= wr_pixel_in;
  end

  always_ff @(posedge pixel_clk_in) begin
    if (w_wr_en && !r_front) r_mem1[wr_addr_in] <= wr_pixel_in;
  end

  always_comb begin
    int v_h, v_v;
    v_h     = int'(hcount_in);
    v_v     = int'(vcount_in);
    w_act   = (v_h < H_ACTIVE) && (v_v < V_ACTIVE);
    // blanking addresses are clamped so the read never leaves the array
    w_raddr = w_act ? ADDR_W'((v_v / SCALE_Y) * FB_WIDTH + (v_h / SCALE_X)) : '0;
  end

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_raddr_d1 <= '0;
      r_act_d1   <= 1'b0;
      r_bank_d1  <= 1'b0;
      r_act_d2   <= 1'b0;
    end else begin
      r_raddr_d1 <= w_raddr;
      r_act_d1   <= w_act;
      r_bank_d1  <= r_front;
      r_act_d2   <= r_act_d1;
    end
  end

  // no reset here so the read register stays BRAM-inferable; output is gated by r_act_d2
  always_ff @(posedge pixel_clk_in) begin
    r_data_d2 <= r_bank_d1 ? r_mem1[r_raddr_d1] : r_mem0[r_raddr_d1];
  end

  assign rgb_out = r_act_d2 ? {r_data_d2[15:11], r_data_d2[15:13],
                               r_data_d2[10:5],  r_data_d2[10:9],
                               r_data_d2[4:0],   r_data_d2[4:2]} : 24'h0;

endmodule

// File: tb/tb_ray_frame_buffer_db.sv
// Bench for ray_frame_buffer_db: directed scenarios then random traffic, checked by a scoreboard
// against a bank/array reference model of the double buffer.
module tb_ray_frame_buffer_db;
  localparam int W = 320;
  localparam int H = 240;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hc = '0;
  logic [9:0]  vc = '0;
  logic        vlast = 1'b0, wv = 1'b0, wl = 1'b0;
  logic [16:0] wa = '0;
  logic [15:0] wp = '0;
  logic        wr_rdy, fb, sp, rp;
  logic [23:0] rgb;

  always #5 clk = ~clk;

  ray_frame_buffer_db dut (
    .pixel_clk_in(clk), .rst_in(rst_n), .hcount_in(hc), .vcount_in(vc),
    .video_last_pixel_in(vlast), .wr_valid_in(wv), .wr_ready_out(wr_rdy),
    .wr_addr_in(wa), .wr_pixel_in(wp), .wr_last_in(wl), .rgb_out(rgb),
    .front_bank_out(fb), .swap_pending_out(sp), .repeat_frame_out(rp)
  );

  typedef struct packed {logic f; logic r; logic p; logic rep;} ctrl_t;

  logic [15:0] m_mem   [2][NPIX];
  bit          m_known [2][NPIX];
  bit          m_front = 1'b0, m_pend = 1'b0;
  ctrl_t       cq[$];
  logic [23:0] rq[$];
  bit          probe_flag = 1'b0, ctrl_flag = 1'b0, probe_d = 1'b0;
  int          total = 0, bad = 0;

  function automatic logic [23:0] expand(input logic [15:0] p);
    int r5, g6, b5, r8, g8, b8;
    r5 = int'(p) / 2048;
    g6 = (int'(p) / 32) % 64;
    b5 = int'(p) % 32;
    r8 = r5 * 8 + r5 / 4;
    g8 = g6 * 4 + g6 / 16;
    b8 = b5 * 8 + b5 / 4;
    return 24'(r8 * 65536 + g8 * 256 + b8);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    ctrl_t c;
    logic [23:0] e;
    if (ctrl_flag) begin
      if (cq.size() == 0) chk("ctrl_queue", 32'd0, 32'd1);
      else begin
        c = cq.pop_front();
        chk("front_bank", 32'(fb), 32'(c.f));
        chk("wr_ready", 32'(wr_rdy), 32'(c.r));
        chk("swap_pending", 32'(sp), 32'(c.p));
        chk("repeat_frame", 32'(rp), 32'(c.rep));
      end
    end
    if (probe_d) begin
      if (rq.size() == 0) chk("rgb_queue", 32'd0, 32'd1);
      else begin
        e = rq.pop_front();
        chk("rgb", 32'(rgb), 32'(e));
      end
    end
    probe_d = probe_flag;
  end

  task automatic step(input bit rst, input int h, input int v, input bit probe,
                      input bit valid, input int addr, input int pix, input bit last,
                      input bit vl);
    bit act, fire, rep, pr;
    int ra;
    logic [23:0] e;
    @(negedge clk); #1;
    rst_n = rst; hc = 11'(h); vc = 10'(v); wv = valid; wa = 17'(addr);
    wp = 16'(pix); wl = last; vlast = vl;
    pr = probe;
    act = (h < W * 4) && (v < H * 3);
    ra = act ? (v / 3) * W + h / 4 : 0;
    e = 24'h0;
    if (rst && act) begin
      if (!m_known[m_front][ra]) pr = 1'b0;
      else e = expand(m_mem[m_front][ra]);
    end
    if (pr) rq.push_back(e);
    probe_flag = pr;
    rep = 1'b0;
    if (!rst) begin
      m_front = 1'b0;
      m_pend  = 1'b0;
    end else begin
      fire = valid && !m_pend;
      if (fire && addr < NPIX) begin
        m_mem[!m_front][addr]   = 16'(pix);
        m_known[!m_front][addr] = 1'b1;
      end
      if (m_pend) begin
        if (vl) begin m_front = !m_front; m_pend = 1'b0; end
      end else if (fire && last) begin
        if (vl) m_front = !m_front;
        else    m_pend = 1'b1;
      end else if (vl) rep = 1'b1;
    end
    cq.push_back('{f: m_front, r: !m_pend, p: m_pend, rep: rep});
    ctrl_flag = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 2000, 1000, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int addr, input int pix, input bit last, input bit vl);
    step(1, 2000, 1000, 0, 1, addr, pix, last, vl);
  endtask

  task automatic rd(input int h, input int v);
    step(1, h, v, 1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle(2);
    // fill bank1 sparsely; last beat on the final address
    wr(0, 16'hF800, 0, 0);
    wr(W + 1, 16'h07E0, 0, 0);
    for (int i = 0; i < 20; i++) wr($urandom_range(2, 2239), $urandom & 16'hFFFF, 0, 0);
    wr(NPIX, 16'hFFFF, 0, 0);
    wr(NPIX - 1, 16'hF800, 1, 0);
    // backpressure: beat held valid while waiting must not land
    for (int i = 0; i < 4; i++) wr(0, 16'h1234, 0, 0);
    step(1, 2000, 1000, 0, 0, 0, 0, 0, 1);
    rd(0, 0);
    for (int v = 3; v <= 5; v++)
      for (int h = 4; h <= 7; h++) rd(h, v);
    rd(1280, 0);
    rd(0, 720);
    rd(1279, 719);
    idle(2);
    // repeat: incomplete back frame at end of video frame
    wr(0, 16'h001F, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0, 0, 1);
    rd(0, 0);
    idle(1);
    // coincident last beat and end of frame
    wr(1, 16'h001F, 1, 1);
    rd(0, 0);
    rd(4, 0);
    wr(5, 16'h0123, 0, 0);
    // mid-stream reset while a swap is pending
    wr(NPIX - 1, 16'hAAAA, 1, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 4, 0, 1, 0, 0, 0, 0, 0);
    idle(2);
    rd(0, 0);
    for (int i = 0; i < 2000; i++) begin
      int h, v, a;
      if (i == 1000 || i == 1001) begin
        step(0, 0, 0, 1, 0, 0, 0, 0, 0);
        continue;
      end
      h = $urandom_range(0, 1400);
      v = ($urandom % 5 == 0) ? $urandom_range(700, 740) : $urandom_range(0, 20);
      a = ($urandom % 10 == 0) ? NPIX + $urandom_range(0, 100) : $urandom_range(0, 2239);
      step(1, h, v, ($urandom % 10) < 7, $urandom % 2, a, $urandom & 16'hFFFF,
           $urandom % 50 == 0, $urandom % 40 == 0);
    end
    idle(3);
    @(negedge clk); #1;
    ctrl_flag = 1'b0;
    probe_flag = 1'b0;
    repeat (3) @(negedge clk);
    chk("queues_drained", 32'(cq.size() + rq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
